ysyx_22041412_mem_arbiter: RTL and testbench

YSYX_22041412_MEM_ARBITER -- requirements
Module: ysyx_22041412_mem_arbiter

---
 rtl/ysyx_22041412_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ysyx_22041412_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_mem_arbiter.sv
// ysyx_22041412_mem_arbiter
// Two-client line arbiter: an I-side fetch port (read-only, abortable) and a
// D-side load/store port share one downstream memory port. At most one
// downstream transaction is in flight. Ties alternate against the last winner.
//
// Handshake summary (all signals sampled on the rising edge of clk):
//   - i_valid / d_valid are level requests, held by the requester until its
//     one-cycle i_ready / d_ready completion pulse (or i_clear for an abort).
//   - m_valid rises the cycle after a grant; m_valid, m_we, m_addr and m_wdata
//     stay frozen until m_ready is sampled high while m_valid is high. m_ready
//     seen while m_valid is low is ignored.
//   - After every ready/clear pulse the arbiter spends that pulse cycle idle
//     (turnaround) so a requester can drop or change its request before the
//     next arbitration.
module ysyx_22041412_mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [31:0]  i_addr,
    input  logic         i_abort,
    output logic         i_ready,
    output logic [127:0] i_rdata,
    output logic         i_clear,
    input  logic         d_valid,
    input  logic         d_we,
    input  logic [31:0]  d_addr,
    input  logic [127:0] d_wdata,
    output logic         d_ready,
    output logic [127:0] d_rdata,
    output logic         m_valid,
    output logic         m_we,
    output logic [31:0]  m_addr,
    output logic [127:0] m_wdata,
    input  logic         m_ready,
    input  logic [127:0] m_rdata,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    localparam logic LG_I = 1'b0;
    localparam logic LG_D = 1'b1;

    state_t         state_q;
    logic           last_grant_q;
    logic           i_ready_q;
    logic           d_ready_q;
    logic           i_clear_q;
    logic [127:0]   i_rdata_q;
    logic [127:0]   d_rdata_q;
    logic           m_valid_q;
    logic           m_we_q;
    logic [31:0]    m_addr_q;
    logic [127:0]   m_wdata_q;

    logic           arb_open;
    logic           i_req;
    logic           d_req;
    logic           win_i;
    logic           win_d;
    logic           m_done;
    logic           unused_addr_bits;

    // Line addresses only: the byte offset inside a line is dropped.
    assign unused_addr_bits = ^{i_addr[3:0], d_addr[3:0]};

    // Arbitration inputs: an I request being aborted this cycle is not eligible.
    always_comb begin
        arb_open = !i_ready_q && !d_ready_q && !i_clear_q;
        i_req    = i_valid && !i_abort;
        d_req    = d_valid;
        win_d    = d_req && (!i_req || (last_grant_q == LG_I));
        win_i    = i_req && !win_d;
        m_done   = m_valid_q && m_ready;
    end

    // Main FSM: grant, hold the downstream request, complete or drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= LG_I;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_clear_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            m_valid_q    <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_clear_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_abort) begin
                        i_clear_q <= 1'b1;
                    end
                    if (arb_open && win_d) begin
                        state_q      <= S_GRANT_D;
                        last_grant_q <= LG_D;
                        m_valid_q    <= 1'b1;
                        m_we_q       <= d_we;
                        m_addr_q     <= {d_addr[31:4], 4'b0};
                        m_wdata_q    <= d_wdata;
                    end else if (arb_open && win_i) begin
                        state_q      <= S_GRANT_I;
                        last_grant_q <= LG_I;
                        m_valid_q    <= 1'b1;
                        m_we_q       <= 1'b0;
                        m_addr_q     <= {i_addr[31:4], 4'b0};
                        m_wdata_q    <= '0;
                    end
                end
                S_GRANT_I: begin
                    if (i_abort) begin
                        if (m_done) begin
                            m_valid_q <= 1'b0;
                            i_clear_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            state_q   <= S_DRAIN;
                        end
                    end else if (m_done) begin
                        m_valid_q <= 1'b0;
                        i_rdata_q <= m_rdata;
                        i_ready_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                S_GRANT_D: begin
                    if (i_abort) begin
                        i_clear_q <= 1'b1;
                    end
                    if (m_done) begin
                        m_valid_q <= 1'b0;
                        if (!m_we_q) begin
                            d_rdata_q <= m_rdata;
                        end
                        d_ready_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (m_done) begin
                        m_valid_q <= 1'b0;
                        i_clear_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign i_ready     = i_ready_q;
    assign d_ready     = d_ready_q;
    assign i_clear     = i_clear_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign m_valid     = m_valid_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_22041412_mem_arbiter.sv
// Bench for ysyx_22041412_mem_arbiter: directed scenarios plus a random phase.
// The downstream side is a behavioural memory; requesters are driver tasks and
// a monitor pops expected completions from per-side queues.
`timescale 1ns/1ps
module tb_ysyx_22041412_mem_arbiter;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_valid = 1'b0;
    logic [31:0]  i_addr = '0;
    logic         i_abort = 1'b0;
    logic         i_ready;
    logic [127:0] i_rdata;
    logic         i_clear;
    logic         d_valid = 1'b0;
    logic         d_we = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [127:0] d_wdata = '0;
    logic         d_ready;
    logic [127:0] d_rdata;
    logic         m_valid;
    logic         m_we;
    logic [31:0]  m_addr;
    logic [127:0] m_wdata;
    logic         m_ready = 1'b0;
    logic [127:0] m_rdata = '0;
    logic [1:0]   dbg_state_unused;

    always #5 clk = ~clk;

    ysyx_22041412_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_abort(i_abort),
        .i_ready(i_ready), .i_rdata(i_rdata), .i_clear(i_clear),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .dbg_state_o(dbg_state_unused)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    // bit 128 set = abort confirmation (i_clear) expected, else read completion
    logic [128:0] i_exp_q[$];
    logic [127:0] d_exp_q[$];
    logic [32:0]  grant_q[$];          // {m_we, m_addr} per downstream issue
    logic [127:0] last_i_rd = '0;
    logic [127:0] last_d_rd = '0;
    int           i_ready_cnt = 0;
    int           i_clear_cnt = 0;
    int           d_ready_cnt = 0;

    // Behavioural memory (responder) and the bench's own D-side model.
    logic [127:0] ram [logic [31:0]];
    logic [127:0] d_model [logic [31:0]];
    int           force_delay = -1;
    logic         rsp_busy = 1'b0;
    int           rsp_wait = 0;
    logic [31:0]  cap_addr;
    logic         cap_we;
    logic [127:0] cap_wdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rom_fn(input logic [31:0] a);
        if (a == 32'h8000_0010) return 128'h0123456789ABCDEF0123456789ABCDEF;
        return {a, ~a, a ^ 32'hdead_beef, a + 32'h0000_1357};
    endfunction

    function automatic logic [127:0] init_fn(input logic [31:0] a);
        return {~a, a, a ^ 32'h0d0d_0d0d, a + 32'h0000_1111};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic i_read(input logic [31:0] addr, input int abort_after);
        logic [31:0] la;
        bit done;
        bit got;
        la = {addr[31:4], 4'b0};
        i_valid = 1'b1;
        i_addr  = addr;
        i_exp_q.push_back({1'b0, rom_fn(la)});
        done = 0;
        for (int cnt = 0; cnt < 300 && !done; cnt++) begin
            @(negedge clk);
            if (i_ready) begin
                done = 1;
            end else if (cnt == abort_after) begin
                i_valid = 1'b0;
                i_abort = 1'b1;
                void'(i_exp_q.pop_back());
                i_exp_q.push_back({1'b1, last_i_rd});
                @(negedge clk);
                i_abort = 1'b0;
                got = 0;
                for (int k = 0; k < 100; k++) begin
                    if (i_clear) begin
                        got = 1;
                        break;
                    end
                    @(negedge clk);
                end
                chk("i_clear_arrives", 128'(got), 128'(1));
                done = 1;
            end
        end
        i_valid = 1'b0;
        if (!done) chk("i_ready_timeout", 128'(0), 128'(1));
    endtask

    task automatic d_req(input logic we, input logic [31:0] addr, input logic [127:0] wdata);
        logic [31:0] la;
        logic [127:0] v;
        bit done;
        la = {addr[31:4], 4'b0};
        d_valid = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        if (we) begin
            d_model[la] = wdata;
            d_exp_q.push_back(last_d_rd);
        end else begin
            v = d_model.exists(la) ? d_model[la] : init_fn(la);
            last_d_rd = v;
            d_exp_q.push_back(v);
        end
        done = 0;
        for (int cnt = 0; cnt < 300 && !done; cnt++) begin
            @(negedge clk);
            if (d_ready) done = 1;
        end
        d_valid = 1'b0;
        if (!done) chk("d_ready_timeout", 128'(0), 128'(1));
    endtask

    // ---------------- downstream memory responder ----------------
    task automatic rsp_fire();
        m_ready = 1'b1;
        if (cap_we) begin
            ram[cap_addr] = cap_wdata;
            m_rdata = rand128();
        end else if (cap_addr[31:28] == 4'h8) begin
            m_rdata = rom_fn(cap_addr);
        end else begin
            m_rdata = ram.exists(cap_addr) ? ram[cap_addr] : init_fn(cap_addr);
        end
    endtask

    // Serve one downstream request at a time; check it stays frozen while stalled.
    always @(negedge clk) begin
        if (rst) begin
            m_ready  = 1'b0;
            rsp_busy = 1'b0;
        end else if (rsp_busy) begin
            if (m_ready) begin
                m_ready  = 1'b0;
                rsp_busy = 1'b0;
                chk("m_valid_drop", 128'(m_valid), 128'(0));
            end else begin
                chk("m_valid_hold", 128'(m_valid), 128'(1));
                chk("m_addr_hold", 128'(m_addr), 128'(cap_addr));
                chk("m_we_hold", 128'(m_we), 128'(cap_we));
                chk("m_wdata_hold", m_wdata, cap_wdata);
                rsp_wait--;
                if (rsp_wait <= 0) rsp_fire();
            end
        end else begin
            m_ready = 1'b0;
            if (m_valid) begin
                rsp_busy  = 1'b1;
                cap_addr  = m_addr;
                cap_we    = m_we;
                cap_wdata = m_wdata;
                grant_q.push_back({m_we, m_addr});
                chk("m_addr_align", 128'(m_addr[3:0]), 128'(0));
                if (m_addr[31:28] == 4'h8) begin
                    chk("m_we_iside", 128'(m_we), 128'(0));
                    chk("m_wdata_iside", m_wdata, 128'(0));
                end
                rsp_wait = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
                if (rsp_wait == 0) rsp_fire();
            end else begin
                // stray m_ready while nothing is outstanding must be ignored
                m_ready = ($urandom_range(0, 3) == 0);
                m_rdata = rand128();
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [128:0] e;
        if (!rst) begin
            if (i_ready) begin
                i_ready_cnt++;
                if (i_exp_q.size() == 0) begin
                    chk("i_ready_unexpected", 128'(1), 128'(0));
                end else begin
                    e = i_exp_q.pop_front();
                    chk("i_ready_kind", 128'(e[128]), 128'(0));
                    chk("i_rdata", i_rdata, e[127:0]);
                    last_i_rd = e[127:0];
                end
            end
            if (i_clear) begin
                i_clear_cnt++;
                if (i_exp_q.size() == 0) begin
                    chk("i_clear_unexpected", 128'(1), 128'(0));
                end else begin
                    e = i_exp_q.pop_front();
                    chk("i_clear_kind", 128'(e[128]), 128'(1));
                    chk("i_rdata_after_abort", i_rdata, e[127:0]);
                end
            end
            if (d_ready) begin
                d_ready_cnt++;
                if (d_exp_q.size() == 0) begin
                    chk("d_ready_unexpected", 128'(1), 128'(0));
                end else begin
                    chk("d_rdata", d_rdata, d_exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        int c1;
        int ab;
        logic [32:0] g;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_m_addr", 128'(m_addr), 128'(0));
        chk("rst_m_we", 128'(m_we), 128'(0));
        chk("rst_m_wdata", m_wdata, 128'(0));
        chk("rst_i_ready", 128'(i_ready), 128'(0));
        chk("rst_d_ready", 128'(d_ready), 128'(0));
        chk("rst_i_clear", 128'(i_clear), 128'(0));
        chk("rst_i_rdata", i_rdata, 128'(0));
        chk("rst_d_rdata", d_rdata, 128'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // I-only read, m_ready three cycles after m_valid
        grant_q.delete();
        force_delay = 3;
        c0 = i_ready_cnt;
        i_read(32'h8000_0014, -1);
        repeat (3) @(negedge clk);
        chk("iread_grants", 128'(grant_q.size()), 128'(1));
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 33'h1_FFFF_FFFF;
        chk("iread_m_addr", 128'(g[31:0]), 128'(32'h8000_0010));
        chk("iread_m_we", 128'(g[32]), 128'(0));
        chk("iread_ready_pulses", 128'(i_ready_cnt - c0), 128'(1));
        chk("iread_i_rdata", i_rdata, 128'h0123456789ABCDEF0123456789ABCDEF);

        // D read (establishes a non-zero d_rdata), then a stalled D write
        force_delay = -1;
        d_req(1'b0, 32'h9000_0038, '0);
        repeat (2) @(negedge clk);
        grant_q.delete();
        force_delay = 10;
        c0 = d_ready_cnt;
        d_req(1'b1, 32'h9000_0020, {4{32'hAAAA_AAAA}});
        repeat (3) @(negedge clk);
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 33'h0;
        chk("stall_m_addr", 128'(g[31:0]), 128'(32'h9000_0020));
        chk("stall_m_we", 128'(g[32]), 128'(1));
        chk("stall_ready_pulses", 128'(d_ready_cnt - c0), 128'(1));
        chk("stall_d_rdata_kept", d_rdata, last_d_rd);

        // abort mid-fetch with a D request waiting (last winner was D, so I wins)
        grant_q.delete();
        force_delay = 6;
        c0 = i_ready_cnt;
        c1 = i_clear_cnt;
        fork
            i_read(32'h8000_0040, 2);
            d_req(1'b0, 32'h9000_0050, '0);
        join
        repeat (3) @(negedge clk);
        force_delay = -1;
        chk("abort_grants", 128'(grant_q.size()), 128'(2));
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 33'h0;
        chk("abort_first_grant", 128'(g[31:0]), 128'(32'h8000_0040));
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 33'h0;
        chk("abort_then_d_grant", 128'(g[31:0]), 128'(32'h9000_0050));
        chk("abort_no_i_ready", 128'(i_ready_cnt - c0), 128'(0));
        chk("abort_one_clear", 128'(i_clear_cnt - c1), 128'(1));
        chk("abort_i_rdata_kept", i_rdata, 128'h0123456789ABCDEF0123456789ABCDEF);

        // reset while an I read is outstanding
        force_delay = 20;
        c0 = i_ready_cnt;
        i_valid = 1'b1;
        i_addr  = 32'h8000_0070;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_m_valid_before", 128'(m_valid), 128'(1));
        rst = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_m_valid", 128'(m_valid), 128'(0));
        chk("rstmid_i_ready", 128'(i_ready), 128'(0));
        chk("rstmid_i_clear", 128'(i_clear), 128'(0));
        chk("rstmid_i_rdata", i_rdata, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        i_exp_q.delete();
        d_exp_q.delete();
        last_i_rd = '0;
        last_d_rd = '0;
        force_delay = -1;
        repeat (4) @(negedge clk);
        chk("rstmid_no_i_ready", 128'(i_ready_cnt - c0), 128'(0));

        // tie after reset: D, I, D, I
        grant_q.delete();
        fork
            begin
                i_read(32'h8000_0100, -1);
                i_read(32'h8000_0200, -1);
            end
            begin
                d_req(1'b0, 32'h9000_0010, '0);
                d_req(1'b0, 32'h9000_0060, '0);
            end
        join
        repeat (3) @(negedge clk);
        chk("tie_grants", 128'(grant_q.size()), 128'(4));
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 33'h0;
        chk("tie_1_d", 128'(g[31:0]), 128'(32'h9000_0010));
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 33'h0;
        chk("tie_2_i", 128'(g[31:0]), 128'(32'h8000_0100));
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 33'h0;
        chk("tie_3_d", 128'(g[31:0]), 128'(32'h9000_0060));
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 33'h0;
        chk("tie_4_i", 128'(g[31:0]), 128'(32'h8000_0200));

        // random traffic on both sides with occasional I aborts
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
                    i_read(32'h8000_0000 | (32'($urandom_range(0, 255)) << 4) | 32'($urandom_range(0, 15)), ab);
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    d_req(1'($urandom_range(0, 1)), 32'h9000_0000 | (32'($urandom_range(0, 7)) << 4), rand128());
                end
            end
        join
        repeat (10) @(negedge clk);
        chk("end_i_queue_empty", 128'(i_exp_q.size()), 128'(0));
        chk("end_d_queue_empty", 128'(d_exp_q.size()), 128'(0));
        chk("end_m_idle", 128'(m_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
